// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scan controller with double-buffered codes
// and a blanked guard interval at the start of every slot. Optional blink: SEG_BLINK_EN.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter int BLINK_DIV   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] digit_codes,
    input  logic        load,
    input  logic [3:0]  blink_mask,
    output logic [4:0]  seg_code,
    output logic [3:0]  anode,
    output logic        frame_done
);
    localparam int            CW         = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
    localparam logic [4:0]    CODE_BLANK = 5'b10011;

    function automatic logic [4:0] sanitize(input logic [4:0] c);
        return (c > CODE_BLANK) ? CODE_BLANK : c;
    endfunction

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][4:0] shadow_q, shadow_d;
    logic [3:0][4:0] active_q, active_d;
    logic [3:0][4:0] load_codes;
    logic [3:0]      anode_q, anode_d;
    logic [4:0]      seg_code_q, seg_code_d;
    logic            frame_done_q, frame_done_d;
    logic            boundary;
    logic            blank_slot;

    assign boundary = (cnt_q == CNT_LAST) && (idx_q == 2'd3);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            load_codes[i] = sanitize(digit_codes[i*5 +: 5]);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int            FW         = $clog2(BLINK_DIV + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (boundary) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blank_slot = blink_phase_q & blink_mask[idx_q];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blank_slot        = 1'b0;
`endif

    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end

        shadow_d = load ? load_codes : shadow_q;

        // A load landing on the boundary cycle goes straight to the displayed frame.
        active_d = active_q;
        if (boundary) begin
            active_d = load ? load_codes : shadow_q;
        end

        frame_done_d = boundary;

        if (cnt_q < GUARD_END) begin
            anode_d    = 4'b1111;
            seg_code_d = CODE_BLANK;
        end else begin
            anode_d    = ~(4'b0001 << idx_q);
            seg_code_d = blank_slot ? CODE_BLANK : active_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= {4{CODE_BLANK}};
            active_q     <= {4{CODE_BLANK}};
            anode_q      <= 4'b1111;
            seg_code_q   <= CODE_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            anode_q      <= anode_d;
            seg_code_q   <= seg_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg_code   = seg_code_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus pushes expected per-slot
// {anode, code} pairs; a negedge monitor pops one per slot and checks every cycle.
module tb_seven_seg_scan_ctrl;
    localparam int         RDIV    = 8;
    localparam int         GRD     = 2;
    localparam int         ACT_LEN = RDIV - GRD;
    localparam int         FRAME   = 4 * RDIV;
    localparam logic [4:0] BL      = 5'b10011;
`ifdef SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] digit_codes;
    logic        load;
    logic [3:0]  blink_mask;
    logic [4:0]  seg_code;
    logic [3:0]  anode;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    seven_seg_scan_ctrl #(.REFRESH_DIV(RDIV), .GUARD(GRD), .BLINK_DIV(2)) dut (
        .clk(clk), .rst(rst), .digit_codes(digit_codes), .load(load),
        .blink_mask(blink_mask), .seg_code(seg_code), .anode(anode),
        .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [4:0] c0, c1, c2, c3);
        exp_q.push_back({4'b1110, c0});
        exp_q.push_back({4'b1101, c1});
        exp_q.push_back({4'b1011, c2});
        exp_q.push_back({4'b0111, c3});
    endtask

    task automatic do_load(input logic [19:0] codes);
        digit_codes = codes;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_done_timeout", {31'd0, seen}, 32'd1);
    endtask

    // Holds rst for 3 cycles, checks reset outputs, then releases and checks the first slot.
    task automatic reset_and_release(input string tag);
        rst = 1'b1;
        repeat (3) tick();
        check({tag, "_anode"}, {28'd0, anode}, 32'hF);
        check({tag, "_seg"}, {27'd0, seg_code}, {27'd0, BL});
        check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
        exp_q.delete();
        push_frame(BL, BL, BL, BL);
        rst  = 1'b0;
        load = 1'b0;
        repeat (2) tick();
        check({tag, "_guard_after_release"}, {28'd0, anode}, 32'hF);
        tick();
        check({tag, "_first_anode"}, {28'd0, anode}, 32'hE);
    endtask

    // Monitor: one queue entry per slot, guard/active run lengths, frame_done spacing.
    logic [8:0] cur;
    bit cur_ok, in_act, skip_grd, fd_valid;
    int act_run, grd_run, cyc, last_fd;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_act   = 1'b0;
            act_run  = 0;
            grd_run  = 0;
            skip_grd = 1'b1;
            fd_valid = 1'b0;
        end else begin
            if (anode == 4'b1111) begin
                if (in_act) begin
                    check("active_len", act_run, ACT_LEN);
                    in_act = 1'b0;
                end
                grd_run++;
                check("guard_seg", {27'd0, seg_code}, {27'd0, BL});
            end else begin
                if (!in_act) begin
                    if (!skip_grd) check("guard_len", grd_run, GRD);
                    skip_grd = 1'b0;
                    grd_run  = 0;
                    act_run  = 0;
                    in_act   = 1'b1;
                    if (exp_q.size() == 0) begin
                        cur_ok = 1'b0;
                        check("queue_underflow", 32'd0, 32'd1);
                    end else begin
                        cur    = exp_q.pop_front();
                        cur_ok = 1'b1;
                    end
                end
                act_run++;
                if (cur_ok) check("slot", {23'd0, anode, seg_code}, {23'd0, cur});
            end
            if (frame_done) begin
                if (fd_valid) check("frame_period", cyc - last_fd, FRAME);
                fd_valid = 1'b1;
                last_fd  = cyc;
            end
        end
    end

    initial begin
        rst = 1'b1;
        load = 1'b0;
        digit_codes = '0;
        blink_mask = 4'b0000;

        reset_and_release("reset");

        // Scan order: {8,3,2,1}
        do_load({5'd8, 5'd3, 5'd2, 5'd1});
        wait_fd();
        push_frame(5'd1, 5'd2, 5'd3, 5'd8);
        wait_fd();
        push_frame(5'd1, 5'd2, 5'd3, 5'd8);

        // No tearing: loads mid-slot 1 only show next frame; last load wins
        repeat (RDIV + 3) tick();
        do_load(20'h00000);
        repeat (3) tick();
        do_load({5'd9, 5'd9, 5'd9, 5'd9});
        wait_fd();
        push_frame(5'd9, 5'd9, 5'd9, 5'd9);

        // Boundary load bypasses the shadow
        repeat (FRAME - 1) tick();
        do_load({5'b10010, 5'b10001, 5'b10000, 5'b01111});
        check("boundary_fd", {31'd0, frame_done}, 32'd1);
        push_frame(5'b01111, 5'b10000, 5'b10001, 5'b10010);

        // Invalid codes are sanitised to blank at capture
        repeat (5) tick();
        do_load({5'd4, 5'd5, 5'd6, 5'b11111});
        wait_fd();
        push_frame(BL, 5'd6, 5'd5, 5'd4);
        do_load({5'b10010, 5'b10011, 5'b10100, 5'b00000});
        wait_fd();
        push_frame(5'b00000, BL, BL, 5'b10010);

        // Reset mid-slot 2 with load asserted: load ignored
        repeat (2 * RDIV + 3) tick();
        digit_codes = {5'd7, 5'd7, 5'd7, 5'd7};
        load = 1'b1;
        reset_and_release("midreset");
        wait_fd();
        push_frame(BL, BL, BL, BL);

        // Blink on digit 0: frames 2,3 after reset blanked, 4,5 shown
        blink_mask = 4'b0001;
        repeat (5) tick();
        do_load({5'd4, 5'd3, 5'd2, 5'd1});
        wait_fd();
        push_frame(BLINK ? BL : 5'd1, 5'd2, 5'd3, 5'd4);
        wait_fd();
        push_frame(BLINK ? BL : 5'd1, 5'd2, 5'd3, 5'd4);
        wait_fd();
        push_frame(5'd1, 5'd2, 5'd3, 5'd4);
        wait_fd();
        push_frame(5'd1, 5'd2, 5'd3, 5'd4);
        wait_fd();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
